// File: rtl/route_pkg.sv
// Shared types and torus neighbour arithmetic for the route walker.
// Nodes are packed {row,col}; each axis wraps modulo 2**dim_bits.
package route_pkg;

    typedef enum logic [1:0] {
        DIR_N = 2'd0,
        DIR_E = 2'd1,
        DIR_S = 2'd2,
        DIR_W = 2'd3
    } dir_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2,
        FAIL = 2'd3
    } state_t;

    // Widest node id the neighbour helper handles (DIM_BITS up to 8).
    localparam int NODE_MAX_W = 16;

    function automatic logic [NODE_MAX_W-1:0] neighbour(
        input logic [NODE_MAX_W-1:0] node,
        input dir_t                  dir,
        input int unsigned           dim_bits
    );
        logic [NODE_MAX_W-1:0] mask;
        logic [NODE_MAX_W-1:0] row;
        logic [NODE_MAX_W-1:0] col;
        mask = NODE_MAX_W'((1 << dim_bits) - 1);
        row  = (node >> dim_bits) & mask;
        col  = node & mask;
        case (dir)
            DIR_N:   row = (row - 1'b1) & mask;
            DIR_E:   col = (col + 1'b1) & mask;
            DIR_S:   row = (row + 1'b1) & mask;
            DIR_W:   col = (col - 1'b1) & mask;
            default: ;
        endcase
        return (row << dim_bits) | col;
    endfunction

endpackage

// File: rtl/dir_fifo.sv
// Direction command queue. Pointers wrap naturally since DEPTH is a power of 2;
// a push is refused when full, a pop is refused when empty.
module dir_fifo
    import route_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic push_i,
    input  dir_t din_i,
    input  logic pop_i,
    output dir_t head_o,
    output logic full_o,
    output logic empty_o
);
    localparam int AW = $clog2(DEPTH);

    dir_t          mem_q [DEPTH];
    logic [AW-1:0] wr_q;
    logic [AW-1:0] rd_q;
    logic [AW:0]   cnt_q;
    logic          do_push;
    logic          do_pop;

    assign full_o  = (cnt_q == (AW+1)'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign head_o  = mem_q[rd_q];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + 1'b1;
            if (do_pop)  rd_q <= rd_q + 1'b1;
            if (do_push && !do_pop)      cnt_q <= cnt_q + 1'b1;
            else if (!do_push && do_pop) cnt_q <= cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_q] <= din_i;
    end

endmodule

// File: rtl/route_walker.sv
// Hop engine: steps the current node one torus hop per accepted command.
//   state | meaning
//   IDLE  | waiting for start
//   RUN   | presenting queued hops downstream
//   DONE  | arrived at destination, done pulses
//   FAIL  | hop budget exhausted, err_budget pulses
module route_walker
    import route_pkg::*;
#(
    parameter int DIM_BITS   = 1,
    parameter int FIFO_DEPTH = 4,
    parameter int MAX_HOPS   = 7
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  start_i,
    input  logic [2*DIM_BITS-1:0] src_node_i,
    input  logic [2*DIM_BITS-1:0] dst_node_i,
    input  logic                  cmd_valid_i,
    input  logic [1:0]            cmd_dir_i,
    output logic                  cmd_ready_o,
    output logic                  hop_valid_o,
    input  logic                  hop_ready_i,
    output logic [2*DIM_BITS-1:0] hop_src_o,
    output logic [1:0]            hop_dir_o,
    output logic [2*DIM_BITS-1:0] hop_dst_o,
    output logic [2*DIM_BITS-1:0] cur_node_o,
    output logic [7:0]            hop_count_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_budget_o
);
    localparam int NW = 2 * DIM_BITS;

    state_t        state_q;
    logic [NW-1:0] cur_q;
    logic [NW-1:0] dst_q;
    logic [7:0]    cnt_q;
    logic          done_q;
    logic          err_q;

    dir_t          head;
    logic          fifo_full;
    logic          fifo_empty;
    logic          hs;
    logic [NW-1:0] next_node;

    dir_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (cmd_valid_i),
        .din_i   (dir_t'(cmd_dir_i)),
        .pop_i   (hs),
        .head_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign next_node   = NW'(neighbour(NODE_MAX_W'(cur_q), head, DIM_BITS));
    assign hop_valid_o = (state_q == RUN) && !fifo_empty;
    assign hs          = hop_valid_o && hop_ready_i;
    assign cmd_ready_o = !fifo_full;
    // Gate head-derived outputs so unwritten queue slots never leak out.
    assign hop_src_o    = cur_q;
    assign hop_dir_o    = hop_valid_o ? head : 2'b00;
    assign hop_dst_o    = hop_valid_o ? next_node : '0;
    assign cur_node_o   = cur_q;
    assign hop_count_o  = cnt_q;
    assign busy_o       = (state_q != IDLE);
    assign done_o       = done_q;
    assign err_budget_o = err_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cur_q   <= '0;
            dst_q   <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        cur_q <= src_node_i;
                        dst_q <= dst_node_i;
                        cnt_q <= '0;
                        if (src_node_i == dst_node_i) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (hs) begin
                        cur_q <= next_node;
                        cnt_q <= cnt_q + 8'd1;
                        if (next_node == dst_q) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else if ((cnt_q + 8'd1) == 8'(MAX_HOPS)) begin
                            state_q <= FAIL;
                            err_q   <= 1'b1;
                        end
                    end
                end
                DONE:    state_q <= IDLE;
                FAIL:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_route_walker.sv
// Directed bench: instance a is the default 2x2 grid, instance b is a 4x4
// grid with a 3-hop budget for wrap and budget scenarios.
module tb_route_walker;

    logic clk;
    logic rst_n;
    int   n_tests = 0;
    int   n_fail  = 0;

    logic       a_start, a_cmd_valid, a_hop_ready;
    logic [1:0] a_src, a_dst, a_cmd_dir;
    logic       a_cmd_ready, a_hop_valid, a_busy, a_done, a_err;
    logic [1:0] a_hop_src, a_hop_dir, a_hop_dst, a_cur;
    logic [7:0] a_cnt;

    logic       b_start, b_cmd_valid, b_hop_ready;
    logic [3:0] b_src, b_dst;
    logic [1:0] b_cmd_dir;
    logic       b_cmd_ready, b_hop_valid, b_busy, b_done, b_err;
    logic [3:0] b_hop_src, b_hop_dst, b_cur;
    logic [1:0] b_hop_dir;
    logic [7:0] b_cnt;

    route_walker #(.DIM_BITS(1), .FIFO_DEPTH(4), .MAX_HOPS(7)) u_a (
        .clk_i(clk), .rst_ni(rst_n), .start_i(a_start),
        .src_node_i(a_src), .dst_node_i(a_dst),
        .cmd_valid_i(a_cmd_valid), .cmd_dir_i(a_cmd_dir), .cmd_ready_o(a_cmd_ready),
        .hop_valid_o(a_hop_valid), .hop_ready_i(a_hop_ready),
        .hop_src_o(a_hop_src), .hop_dir_o(a_hop_dir), .hop_dst_o(a_hop_dst),
        .cur_node_o(a_cur), .hop_count_o(a_cnt), .busy_o(a_busy),
        .done_o(a_done), .err_budget_o(a_err)
    );

    route_walker #(.DIM_BITS(2), .FIFO_DEPTH(4), .MAX_HOPS(3)) u_b (
        .clk_i(clk), .rst_ni(rst_n), .start_i(b_start),
        .src_node_i(b_src), .dst_node_i(b_dst),
        .cmd_valid_i(b_cmd_valid), .cmd_dir_i(b_cmd_dir), .cmd_ready_o(b_cmd_ready),
        .hop_valid_o(b_hop_valid), .hop_ready_i(b_hop_ready),
        .hop_src_o(b_hop_src), .hop_dir_o(b_hop_dir), .hop_dst_o(b_hop_dst),
        .cur_node_o(b_cur), .hop_count_o(b_cnt), .busy_o(b_busy),
        .done_o(b_done), .err_budget_o(b_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        a_start = 0; a_cmd_valid = 0; a_hop_ready = 0; a_src = 0; a_dst = 0; a_cmd_dir = 0;
        b_start = 0; b_cmd_valid = 0; b_hop_ready = 0; b_src = 0; b_dst = 0; b_cmd_dir = 0;
        cyc(); cyc();
        n_tests++; if (a_cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_cmd_ready: got %b expected 1", a_cmd_ready); end
        n_tests++; if (a_hop_valid !== 1'b0) begin n_fail++; $display("FAIL reset_hop_valid: got %b expected 0", a_hop_valid); end
        n_tests++; if (a_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", a_busy); end
        n_tests++; if (a_cur !== 2'd0) begin n_fail++; $display("FAIL reset_cur: got %0d expected 0", a_cur); end
        n_tests++; if (a_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", a_cnt); end
        n_tests++; if ({a_done, a_err, a_hop_dir, a_hop_dst} !== 6'd0) begin n_fail++; $display("FAIL reset_outs: got %b expected 000000", {a_done, a_err, a_hop_dir, a_hop_dst}); end
        rst_n = 1'b1;
        cyc();
    endtask

    task automatic test_basic_route();
        a_cmd_valid = 1; a_cmd_dir = 2'd1; cyc();
        a_cmd_dir = 2'd2; cyc();
        a_cmd_valid = 0;
        a_src = 2'd0; a_dst = 2'd3; a_hop_ready = 1; a_start = 1; cyc();
        a_start = 0;
        n_tests++; if ({a_busy, a_hop_valid} !== 2'b11) begin n_fail++; $display("FAIL basic_first_valid: got %b expected 11", {a_busy, a_hop_valid}); end
        n_tests++; if ({a_hop_src, a_hop_dir, a_hop_dst} !== {2'd0, 2'd1, 2'd1}) begin n_fail++; $display("FAIL basic_hop1: got %b expected 000101", {a_hop_src, a_hop_dir, a_hop_dst}); end
        cyc();
        n_tests++; if ({a_hop_src, a_hop_dir, a_hop_dst} !== {2'd1, 2'd2, 2'd3}) begin n_fail++; $display("FAIL basic_hop2: got %b expected 011011", {a_hop_src, a_hop_dir, a_hop_dst}); end
        n_tests++; if (a_cnt !== 8'd1) begin n_fail++; $display("FAIL basic_count1: got %0d expected 1", a_cnt); end
        cyc();
        n_tests++; if ({a_done, a_err, a_hop_valid} !== 3'b100) begin n_fail++; $display("FAIL basic_done: got %b expected 100", {a_done, a_err, a_hop_valid}); end
        n_tests++; if ({a_cur, a_cnt} !== {2'd3, 8'd2}) begin n_fail++; $display("FAIL basic_final: got cur %0d cnt %0d expected cur 3 cnt 2", a_cur, a_cnt); end
        cyc();
        n_tests++; if ({a_done, a_busy} !== 2'b00) begin n_fail++; $display("FAIL basic_idle: got %b expected 00", {a_done, a_busy}); end
    endtask

    task automatic test_same_node();
        a_src = 2'd2; a_dst = 2'd2; a_start = 1; cyc();
        a_start = 0;
        n_tests++; if ({a_done, a_hop_valid, a_busy} !== 3'b101) begin n_fail++; $display("FAIL same_done: got %b expected 101", {a_done, a_hop_valid, a_busy}); end
        n_tests++; if ({a_cur, a_cnt} !== {2'd2, 8'd0}) begin n_fail++; $display("FAIL same_cur: got cur %0d cnt %0d expected cur 2 cnt 0", a_cur, a_cnt); end
        cyc();
        n_tests++; if ({a_done, a_busy} !== 2'b00) begin n_fail++; $display("FAIL same_idle: got %b expected 00", {a_done, a_busy}); end
    endtask

    task automatic test_back_to_back();
        logic [1:0] dirs [4];
        dirs[0] = 2'd3; dirs[1] = 2'd0; dirs[2] = 2'd1; dirs[3] = 2'd2;
        a_hop_ready = 0; a_src = 2'd0; a_dst = 2'd3; a_start = 1; cyc();
        a_start = 0;
        n_tests++; if ({a_busy, a_hop_valid} !== 2'b10) begin n_fail++; $display("FAIL bp_empty_run: got %b expected 10", {a_busy, a_hop_valid}); end
        a_cmd_valid = 1;
        for (int i = 0; i < 4; i++) begin
            a_cmd_dir = dirs[i];
            cyc();
            n_tests++; if ({a_hop_valid, a_hop_src, a_hop_dir, a_hop_dst} !== {1'b1, 2'd0, 2'd3, 2'd1}) begin n_fail++; $display("FAIL bp_stable_%0d: got %b expected 1001101", i, {a_hop_valid, a_hop_src, a_hop_dir, a_hop_dst}); end
        end
        a_cmd_valid = 0;
        n_tests++; if (a_cmd_ready !== 1'b0) begin n_fail++; $display("FAIL bp_full: got %b expected 0", a_cmd_ready); end
        cyc();
        n_tests++; if ({a_hop_dir, a_cur, a_cnt} !== {2'd3, 2'd0, 8'd0}) begin n_fail++; $display("FAIL bp_no_pop: got dir %0d cur %0d cnt %0d expected 3 0 0", a_hop_dir, a_cur, a_cnt); end
        a_hop_ready = 1; cyc();
        n_tests++; if ({a_cur, a_hop_dir, a_hop_dst, a_cmd_ready} !== {2'd1, 2'd0, 2'd3, 1'b1}) begin n_fail++; $display("FAIL bp_release: got %b expected 0100111", {a_cur, a_hop_dir, a_hop_dst, a_cmd_ready}); end
        cyc();
        n_tests++; if ({a_done, a_cur, a_cnt} !== {1'b1, 2'd3, 8'd2}) begin n_fail++; $display("FAIL bp_done: got done %b cur %0d cnt %0d expected 1 3 2", a_done, a_cur, a_cnt); end
        cyc();
    endtask

    task automatic test_torus_wrap();
        b_cmd_valid = 1; b_cmd_dir = 2'd1; cyc();
        b_cmd_valid = 0;
        b_src = 4'd3; b_dst = 4'd0; b_hop_ready = 1; b_start = 1; cyc();
        b_start = 0;
        n_tests++; if ({b_hop_valid, b_hop_src, b_hop_dst} !== {1'b1, 4'd3, 4'd0}) begin n_fail++; $display("FAIL wrap_east: got %b expected 100110000", {b_hop_valid, b_hop_src, b_hop_dst}); end
        cyc();
        n_tests++; if ({b_done, b_cur, b_cnt} !== {1'b1, 4'd0, 8'd1}) begin n_fail++; $display("FAIL wrap_done: got done %b cur %0d cnt %0d expected 1 0 1", b_done, b_cur, b_cnt); end
        cyc();
    endtask

    task automatic test_budget();
        logic [1:0] dirs [4];
        dirs[0] = 2'd1; dirs[1] = 2'd1; dirs[2] = 2'd1; dirs[3] = 2'd0;
        b_cmd_valid = 1;
        for (int i = 0; i < 4; i++) begin
            b_cmd_dir = dirs[i];
            cyc();
        end
        b_cmd_valid = 0;
        n_tests++; if (b_cmd_ready !== 1'b0) begin n_fail++; $display("FAIL budget_full: got %b expected 0", b_cmd_ready); end
        b_src = 4'd0; b_dst = 4'd5; b_hop_ready = 1; b_start = 1; cyc();
        b_start = 0;
        n_tests++; if (b_hop_dst !== 4'd1) begin n_fail++; $display("FAIL budget_hop1: got %0d expected 1", b_hop_dst); end
        cyc();
        cyc();
        n_tests++; if ({b_cur, b_cnt, b_hop_dst} !== {4'd2, 8'd2, 4'd3}) begin n_fail++; $display("FAIL budget_hop3: got cur %0d cnt %0d dst %0d expected 2 2 3", b_cur, b_cnt, b_hop_dst); end
        cyc();
        n_tests++; if ({b_err, b_done, b_hop_valid} !== 3'b100) begin n_fail++; $display("FAIL budget_err: got %b expected 100", {b_err, b_done, b_hop_valid}); end
        n_tests++; if ({b_cur, b_cnt, b_cmd_ready} !== {4'd3, 8'd3, 1'b1}) begin n_fail++; $display("FAIL budget_final: got cur %0d cnt %0d rdy %b expected 3 3 1", b_cur, b_cnt, b_cmd_ready); end
        cyc();
        n_tests++; if ({b_err, b_busy} !== 2'b00) begin n_fail++; $display("FAIL budget_idle: got %b expected 00", {b_err, b_busy}); end
        b_src = 4'd0; b_dst = 4'd12; b_start = 1; cyc();
        b_start = 0;
        n_tests++; if ({b_hop_valid, b_hop_dir, b_hop_dst} !== {1'b1, 2'd0, 4'd12}) begin n_fail++; $display("FAIL leftover_north: got %b expected 1001100", {b_hop_valid, b_hop_dir, b_hop_dst}); end
        cyc();
        n_tests++; if ({b_done, b_cur} !== {1'b1, 4'd12}) begin n_fail++; $display("FAIL leftover_done: got done %b cur %0d expected 1 12", b_done, b_cur); end
        cyc();
    endtask

    task automatic test_reset_mid_run();
        a_hop_ready = 0; a_src = 2'd1; a_dst = 2'd2; a_start = 1; cyc();
        a_start = 0;
        n_tests++; if ({a_hop_valid, a_hop_dir, a_cur} !== {1'b1, 2'd1, 2'd1}) begin n_fail++; $display("FAIL midrst_pre: got %b expected 10101", {a_hop_valid, a_hop_dir, a_cur}); end
        #3;
        rst_n = 1'b0;
        #1;
        n_tests++; if ({a_busy, a_hop_valid, a_cmd_ready, a_cur} !== {1'b0, 1'b0, 1'b1, 2'd0}) begin n_fail++; $display("FAIL midrst_async: got %b expected 00100", {a_busy, a_hop_valid, a_cmd_ready, a_cur}); end
        cyc();
        rst_n = 1'b1;
        cyc();
        a_hop_ready = 1; a_start = 1; cyc();
        a_start = 0;
        n_tests++; if ({a_busy, a_hop_valid} !== 2'b10) begin n_fail++; $display("FAIL midrst_queue_cleared: got %b expected 10", {a_busy, a_hop_valid}); end
    endtask

    initial begin
        test_reset();
        test_basic_route();
        test_same_node();
        test_back_to_back();
        test_torus_wrap();
        test_budget();
        test_reset_mid_run();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached before summary");
        $fatal(1);
    end

endmodule
